mac_operand_sequencer: RTL and testbench

Upstream feeder for the 3-lane MAC in the LSTM datapath. Given a vector length and a bias, it walks the operand buffer in groups of three weight/input pairs and presents each group to the MAC. It chains the MAC result back as the next group's pre-sum, zero-pads the final partial group, and returns the full dot product (bias + Σ w·x) through a valid/ready output.

---
 rtl/mac_operand_sequencer_pkg.sv | 48 ++++
 rtl/mac_operand_sequencer_if.sv | 29 ++
 rtl/mac_operand_sequencer_lane_mask.sv | 18 +
 rtl/mac_operand_sequencer.sv | 124 ++++++++++++
 tb/tb_mac_operand_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_operand_sequencer_pkg.sv
// Shared types and lane helpers for the MAC operand sequencer.
package lstm_mac_pkg;

    localparam int unsigned MAC_LANES  = 3;
    localparam int unsigned LANE_MAX_W = 32;
    localparam int unsigned LANE_BUS_W = MAC_LANES * LANE_MAX_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        DRAIN,
        OUT
    } seq_state_e;

    function automatic logic [LANE_MAX_W-1:0] lane_mask(input int unsigned w);
        logic [LANE_MAX_W-1:0] m;
        if (w >= LANE_MAX_W)
            m = '1;
        else
            m = LANE_MAX_W'((64'(1) << w) - 64'(1));
        return m;
    endfunction

    // Lane k of a packed bus whose lanes are w bits wide, zero-extended.
    function automatic logic [LANE_MAX_W-1:0] lane_get(
        input logic [LANE_BUS_W-1:0] bus,
        input int unsigned           k,
        input int unsigned           w
    );
        logic [LANE_BUS_W-1:0] sh;
        sh = bus >> (k * w);
        return sh[LANE_MAX_W-1:0] & lane_mask(w);
    endfunction

    function automatic logic [LANE_BUS_W-1:0] lane_put(
        input logic [LANE_BUS_W-1:0] bus,
        input int unsigned           k,
        input int unsigned           w,
        input logic [LANE_MAX_W-1:0] val
    );
        logic [LANE_BUS_W-1:0] field;
        field = LANE_BUS_W'(lane_mask(w)) << (k * w);
        return (bus & ~field) | ((LANE_BUS_W'(val & lane_mask(w))) << (k * w));
    endfunction

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// Request/response bundle between the operand sequencer and the 3-lane MAC.
interface mac_operand_sequencer_if #(
    parameter int unsigned W_BITWIDTH   = 8,
    parameter int unsigned IN_BITWIDTH  = 8,
    parameter int unsigned OUT_BITWIDTH = 32
);
    logic                    mac_en;
    logic [W_BITWIDTH-1:0]   mac_weights_0;
    logic [W_BITWIDTH-1:0]   mac_weights_1;
    logic [W_BITWIDTH-1:0]   mac_weights_2;
    logic [IN_BITWIDTH-1:0]  mac_data_in_0;
    logic [IN_BITWIDTH-1:0]  mac_data_in_1;
    logic [IN_BITWIDTH-1:0]  mac_data_in_2;
    logic [OUT_BITWIDTH-1:0] mac_pre_sum;
    logic                    mac_done;
    logic [OUT_BITWIDTH-1:0] mac_out;

    modport master (
        output mac_en, mac_weights_0, mac_weights_1, mac_weights_2,
               mac_data_in_0, mac_data_in_1, mac_data_in_2, mac_pre_sum,
        input  mac_done, mac_out
    );

    modport slave (
        input  mac_en, mac_weights_0, mac_weights_1, mac_weights_2,
               mac_data_in_0, mac_data_in_1, mac_data_in_2, mac_pre_sum,
        output mac_done, mac_out
    );
endinterface

// File: rtl/mac_operand_sequencer_lane_mask.sv
// Flags which lanes of group g hold real elements (3g+k < len).
module mac_lane_mask
    import lstm_mac_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LEN_W  = 7
) (
    input  logic [ADDR_W-1:0]    g,
    input  logic [LEN_W-1:0]     len,
    output logic [MAC_LANES-1:0] lane_valid
);
    always_comb begin
        lane_valid = '0;
        for (int unsigned k = 0; k < MAC_LANES; k++) begin
            lane_valid[k] = (32'(g) * 32'(MAC_LANES) + k) < 32'(len);
        end
    end
endmodule

// File: rtl/mac_operand_sequencer.sv
// Walks the operand buffer three elements at a time, chaining MAC results into a dot product.
module mac_operand_sequencer
    import lstm_mac_pkg::*;
#(
    parameter int unsigned W_BITWIDTH   = 8,
    parameter int unsigned IN_BITWIDTH  = 8,
    parameter int unsigned OUT_BITWIDTH = 32,
    parameter int unsigned MAX_LEN      = 64,
    parameter int unsigned ADDR_W       = $clog2((MAX_LEN + 2) / 3)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [$clog2(MAX_LEN+1)-1:0]      len,
    input  logic [OUT_BITWIDTH-1:0]           bias,
    output logic                              busy,
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    input  logic [MAC_LANES*W_BITWIDTH-1:0]   rd_weight,
    input  logic [MAC_LANES*IN_BITWIDTH-1:0]  rd_data,
    mac_operand_sequencer_if.master           mac,
    output logic                              result_valid,
    output logic [OUT_BITWIDTH-1:0]           result,
    input  logic                              result_ready
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned GRP_W = ADDR_W + 1;

    seq_state_e state_q, state_d;

    logic [LEN_W-1:0]        len_q, len_c;
    logic [GRP_W-1:0]        groups_q;
    logic [ADDR_W-1:0]       g_q;
    logic [OUT_BITWIDTH-1:0] acc_q;
    logic [OUT_BITWIDTH-1:0] pre_sum_q;
    logic [W_BITWIDTH-1:0]   w_q [MAC_LANES];
    logic [IN_BITWIDTH-1:0]  x_q [MAC_LANES];
    logic [MAC_LANES-1:0]    lane_valid;
    logic                    accept, drain_exit, last_group;

    assign len_c      = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign accept     = (state_q == IDLE) && start;
    assign drain_exit = (state_q == DRAIN) && !mac.mac_done;
    assign last_group = (GRP_W'(g_q) + GRP_W'(1)) == groups_q;

    mac_lane_mask #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_lane_mask (
        .g         (g_q),
        .len       (len_q),
        .lane_valid(lane_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? OUT : FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = ISSUE;
            ISSUE:   if (mac.mac_done) state_d = DRAIN;
            DRAIN:   if (!mac.mac_done) state_d = last_group ? OUT : FETCH;
            OUT:     if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            groups_q  <= '0;
            g_q       <= '0;
            acc_q     <= '0;
            pre_sum_q <= '0;
            for (int unsigned k = 0; k < MAC_LANES; k++) begin
                w_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                len_q    <= len_c;
                groups_q <= GRP_W'((32'(len_c) + 32'd2) / 32'd3);
                g_q      <= '0;
                acc_q    <= bias;
            end
            // Buffer data is one cycle behind rd_en, so it lands here in LOAD.
            if (state_q == LOAD) begin
                for (int unsigned k = 0; k < MAC_LANES; k++) begin
                    w_q[k] <= lane_valid[k]
                        ? W_BITWIDTH'(lane_get(LANE_BUS_W'(rd_weight), k, W_BITWIDTH)) : '0;
                    x_q[k] <= lane_valid[k]
                        ? IN_BITWIDTH'(lane_get(LANE_BUS_W'(rd_data), k, IN_BITWIDTH)) : '0;
                end
                pre_sum_q <= acc_q;
            end
            if (drain_exit) begin
                acc_q <= mac.mac_out;
                g_q   <= g_q + 1'b1;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign rd_en        = (state_q == FETCH);
    assign rd_addr      = g_q;
    assign result_valid = (state_q == OUT);
    assign result       = acc_q;

    assign mac.mac_en        = (state_q == ISSUE);
    assign mac.mac_weights_0 = w_q[0];
    assign mac.mac_weights_1 = w_q[1];
    assign mac.mac_weights_2 = w_q[2];
    assign mac.mac_data_in_0 = x_q[0];
    assign mac.mac_data_in_1 = x_q[1];
    assign mac.mac_data_in_2 = x_q[2];
    assign mac.mac_pre_sum   = pre_sum_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench: behavioural MAC and operand buffer, result scoreboard, burst log.
module tb_mac_operand_sequencer;
    import lstm_mac_pkg::*;

    localparam int unsigned W       = 8;
    localparam int unsigned IN      = 8;
    localparam int unsigned OW      = 32;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned ADDR_W  = $clog2((MAX_LEN + 2) / 3);
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [31:0] pre;
        logic [7:0]  w0, w1, w2, x0, x1, x2;
    } burst_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [OW-1:0]     bias = '0;
    logic              busy, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [3*W-1:0]    rd_weight = '0;
    logic [3*IN-1:0]   rd_data = '0;
    logic              result_valid;
    logic [OW-1:0]     result;
    logic              result_ready = 1'b1;

    logic [3*W-1:0]    wmem [32];
    logic [3*IN-1:0]   xmem [32];
    logic [31:0]       exp_q [$];
    burst_t            mlog [$];
    int                tests = 0;
    int                fails = 0;
    int                rd_cnt = 0;
    logic              mac_prev = 1'b0;
    logic [3:0]        mcnt;

    mac_operand_sequencer_if #(.W_BITWIDTH(W), .IN_BITWIDTH(IN), .OUT_BITWIDTH(OW)) mac_bus ();

    mac_operand_sequencer #(
        .W_BITWIDTH  (W),
        .IN_BITWIDTH (IN),
        .OUT_BITWIDTH(OW),
        .MAX_LEN     (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .len         (len),
        .bias        (bias),
        .busy        (busy),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_weight   (rd_weight),
        .rd_data     (rd_data),
        .mac         (mac_bus),
        .result_valid(result_valid),
        .result      (result),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_weight <= wmem[rd_addr];
            rd_data   <= xmem[rd_addr];
        end
    end

    // MAC model: three enabled cycles of latency, done held until mac_en drops.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mac_bus.mac_done <= 1'b0;
            mac_bus.mac_out  <= '0;
            mcnt             <= '0;
        end else if (mac_bus.mac_en && !mac_bus.mac_done) begin
            if (mcnt == 4'd2) begin
                mac_bus.mac_done <= 1'b1;
                mac_bus.mac_out  <= mac_bus.mac_pre_sum
                    + 32'(mac_bus.mac_weights_0) * 32'(mac_bus.mac_data_in_0)
                    + 32'(mac_bus.mac_weights_1) * 32'(mac_bus.mac_data_in_1)
                    + 32'(mac_bus.mac_weights_2) * 32'(mac_bus.mac_data_in_2);
                mcnt <= '0;
            end else begin
                mcnt <= mcnt + 4'd1;
            end
        end else if (mac_bus.mac_done && !mac_bus.mac_en) begin
            mac_bus.mac_done <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            mac_prev = 1'b0;
        end else begin
            if (rd_en) rd_cnt++;
            if (mac_bus.mac_en && !mac_prev) begin
                burst_t b;
                b.pre = mac_bus.mac_pre_sum;
                b.w0 = mac_bus.mac_weights_0; b.w1 = mac_bus.mac_weights_1; b.w2 = mac_bus.mac_weights_2;
                b.x0 = mac_bus.mac_data_in_0; b.x1 = mac_bus.mac_data_in_1; b.x2 = mac_bus.mac_data_in_2;
                mlog.push_back(b);
            end
            mac_prev = mac_bus.mac_en;
            if (result_valid && result_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %0d, required no result", result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
        end
    end

    task automatic fill_junk();
        for (int g = 0; g < 32; g++) begin
            wmem[g] = '1;
            xmem[g] = '1;
        end
    endtask

    task automatic set_elem(input int e, input int wv, input int xv);
        int g;
        int unsigned k;
        g = e / 3;
        k = 32'(e % 3);
        wmem[g] = (3*W)'(lane_put(LANE_BUS_W'(wmem[g]), k, W, 32'(wv)));
        xmem[g] = (3*IN)'(lane_put(LANE_BUS_W'(xmem[g]), k, IN, 32'(xv)));
    endtask

    task automatic start_job(input int l, input logic [31:0] b, input logic [31:0] e);
        exp_q.push_back(e);
        rd_cnt = 0;
        mlog.delete();
        @(posedge clk); #1;
        start = 1'b1;
        len = LEN_W'(l);
        bias = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("done_before_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 0);
        check({tag, "_mac_en"}, 32'(mac_bus.mac_en), 0);
        check({tag, "_operands"}, {mac_bus.mac_weights_0, mac_bus.mac_weights_1,
              mac_bus.mac_weights_2, mac_bus.mac_data_in_0}, 0);
        check({tag, "_operands_hi"}, 32'({mac_bus.mac_data_in_1, mac_bus.mac_data_in_2}), 0);
        check({tag, "_pre_sum"}, mac_bus.mac_pre_sum, 0);
        check({tag, "_result_valid"}, 32'(result_valid), 0);
        check({tag, "_result"}, result, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_junk();
        #2;
        check_reset_vals("reset");
        #20;
        @(negedge clk) rstn = 1'b1;

        // len=3: one group, 10 + 1*4 + 2*5 + 3*6 = 42; checks FETCH at 1, mac_en from 3
        fill_junk();
        set_elem(0, 1, 4); set_elem(1, 2, 5); set_elem(2, 3, 6);
        start_job(3, 32'd10, 32'd42);
        @(negedge clk); check("t1_rd_en_cycle1", 32'(rd_en), 1);
        @(negedge clk); check("t1_mac_en_cycle2", 32'(mac_bus.mac_en), 0);
        @(negedge clk); check("t1_mac_en_cycle3", 32'(mac_bus.mac_en), 1);
        wait_done(200);
        check("t1_reads", rd_cnt, 1);
        check("t1_bursts", mlog.size(), 1);
        check("t1_busy_after", 32'(busy), 0);

        // len=4: second group keeps lane 0 only, pre_sum 6, result 10
        fill_junk();
        for (int e = 0; e < 4; e++) set_elem(e, 1, e + 1);
        start_job(4, 32'd0, 32'd10);
        wait_done(300);
        check("t2_reads", rd_cnt, 2);
        check("t2_bursts", mlog.size(), 2);
        if (mlog.size() >= 2) begin
            check("t2_g0_pre", mlog[0].pre, 0);
            check("t2_g1_pre", mlog[1].pre, 6);
            check("t2_g1_lane0", {mlog[1].w0, mlog[1].x0}, 16'h0104);
            check("t2_g1_pad", {mlog[1].w1, mlog[1].w2, mlog[1].x1, mlog[1].x2}, 0);
        end

        // len=0: straight to OUT with bias
        start_job(0, 32'd7, 32'd7);
        @(negedge clk); check("t3_valid_cycle1", 32'(result_valid), 1);
        wait_done(50);
        check("t3_reads", rd_cnt, 0);
        check("t3_bursts", mlog.size(), 0);

        // Backpressure: 1 + 3*(2*3) = 19 held while ready low; stray starts ignored
        fill_junk();
        for (int e = 0; e < 3; e++) set_elem(e, 2, 3);
        result_ready = 1'b0;
        start_job(3, 32'd1, 32'd19);
        for (int i = 0; i < 200; i++) begin
            if (result_valid) break;
            @(negedge clk);
        end
        check("t4_valid_seen", 32'(result_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = (c == 2);
            check("t4_hold_result", result, 19);
            check("t4_hold_valid", 32'(result_valid), 1);
            check("t4_hold_busy", 32'(busy), 1);
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_busy_after_handshake", 32'(busy), 0);
        repeat (4) @(negedge clk);
        check("t4_no_restart_reads", rd_cnt, 1);
        check("t4_scoreboard_empty", exp_q.size(), 0);

        // Reset in the second ISSUE, then a clean rerun: 6 + 6 = 12
        fill_junk();
        set_elem(0, 1, 1); set_elem(1, 1, 2); set_elem(2, 1, 3);
        for (int e = 3; e < 6; e++) set_elem(e, 2, 1);
        start_job(6, 32'd0, 32'd12);
        for (int i = 0; i < 300; i++) begin
            if (mlog.size() >= 2) break;
            @(negedge clk);
        end
        check("t5_second_issue_seen", 32'(mac_bus.mac_en), 1);
        #1 rstn = 1'b0;
        #1 check_reset_vals("t5_midreset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_result_after_reset", 32'(result_valid), 0);
        start_job(6, 32'd0, 32'd12);
        wait_done(300);
        check("t5_rerun_bursts", mlog.size(), 2);

        // len beyond MAX_LEN clamps to 64: 22 groups, 100 + 64 = 164
        fill_junk();
        for (int e = 0; e < 64; e++) set_elem(e, 1, 1);
        start_job(MAX_LEN + 5, 32'd100, 32'd164);
        wait_done(3000);
        check("t6_reads", rd_cnt, 22);
        check("t6_bursts", mlog.size(), 22);
        if (mlog.size() == 22) begin
            check("t6_last_pre", mlog[21].pre, 163);
            check("t6_last_lanes", {mlog[21].w0, mlog[21].w1, mlog[21].w2,
                  mlog[21].x0}, 32'h01000001);
            check("t6_last_pad_x", {mlog[21].x1, mlog[21].x2}, 0);
        end

        // Accumulator wraps: 0xFFFFFFFF + 1*2 = 1
        fill_junk();
        set_elem(0, 1, 2); set_elem(1, 0, 0); set_elem(2, 0, 0);
        start_job(3, 32'hFFFF_FFFF, 32'd1);
        wait_done(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
